// File: rtl/alu_mul_sequencer.sv
// Shift-add multiplier controller that borrows the shared ALU to produce the low word of op_a*op_b.
// Optional macro MUL_EARLY_EXIT_EN ends iteration once the remaining multiplier bits are all zero.
module alu_mul_sequencer #(
    parameter int DATA_WIDTH    = 32,
    parameter int OPCODE_LENGTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic [DATA_WIDTH-1:0]    op_a,
    input  logic [DATA_WIDTH-1:0]    op_b,
    output logic                     busy,
    output logic                     done,
    output logic [DATA_WIDTH-1:0]    result,
    output logic                     alu_req,
    output logic [DATA_WIDTH-1:0]    alu_srca,
    output logic [DATA_WIDTH-1:0]    alu_srcb,
    output logic [OPCODE_LENGTH-1:0] alu_op,
    input  logic [DATA_WIDTH-1:0]    alu_result
);

    localparam logic [OPCODE_LENGTH-1:0] ALU_ADD   = OPCODE_LENGTH'(4'b0010);
    localparam logic [OPCODE_LENGTH-1:0] ALU_IDLE  = OPCODE_LENGTH'(4'b0000);
    localparam logic [5:0]               LAST_CNT  = 6'd31;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ITER = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t                  state_q, state_d;
    logic [DATA_WIDTH-1:0]   acc_q, acc_d;
    logic [DATA_WIDTH-1:0]   mcand_q, mcand_d;
    logic [DATA_WIDTH-1:0]   mplier_q, mplier_d;
    logic [5:0]              count_q, count_d;
    logic [DATA_WIDTH-1:0]   result_q, result_d;
    logic                    busy_q, busy_d;
    logic                    done_q, done_d;
    logic                    alu_req_q, alu_req_d;
    logic                    last_iter_s;

    // Final-iteration detection: fixed count, or no remaining multiplier bits above bit 0.
    always_comb begin
`ifdef MUL_EARLY_EXIT_EN
        last_iter_s = (mplier_q[DATA_WIDTH-1:1] == '0);
`else
        last_iter_s = (count_q == LAST_CNT);
`endif
    end

    // ALU operand drive; zeroed whenever the sequencer does not own the ALU.
    always_comb begin
        if (state_q == S_ITER) begin
            alu_srca = acc_q;
            alu_srcb = mplier_q[0] ? mcand_q : '0;
            alu_op   = ALU_ADD;
        end else begin
            alu_srca = '0;
            alu_srcb = '0;
            alu_op   = ALU_IDLE;
        end
    end

    // Next-state and datapath update; status flags are computed from the next state.
    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        mcand_d   = mcand_q;
        mplier_d  = mplier_q;
        count_d   = count_q;
        result_d  = result_q;
        busy_d    = 1'b0;
        done_d    = 1'b0;
        alu_req_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    acc_d     = '0;
                    mcand_d   = op_a;
                    mplier_d  = op_b;
                    count_d   = 6'd0;
                    state_d   = S_ITER;
                    busy_d    = 1'b1;
                    alu_req_d = 1'b1;
                end else begin
                    state_d   = S_IDLE;
                end
            end
            S_ITER: begin
                acc_d    = alu_result;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                count_d  = count_q + 6'd1;
                if (last_iter_s) begin
                    result_d = alu_result;
                    state_d  = S_DONE;
                    done_d   = 1'b1;
                end else begin
                    state_d   = S_ITER;
                    busy_d    = 1'b1;
                    alu_req_d = 1'b1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State register; reset aborts any operation in flight without a done pulse.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_IDLE;
            acc_q     <= '0;
            mcand_q   <= '0;
            mplier_q  <= '0;
            count_q   <= 6'd0;
            result_q  <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            alu_req_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            mcand_q   <= mcand_d;
            mplier_q  <= mplier_d;
            count_q   <= count_d;
            result_q  <= result_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            alu_req_q <= alu_req_d;
        end
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign alu_req = alu_req_q;
    assign result  = result_q;

endmodule

// File: tb/tb_alu_mul_sequencer.sv
// Directed bench for alu_mul_sequencer with a behavioural ALU; adapts iteration count to MUL_EARLY_EXIT_EN.
module tb_alu_mul_sequencer;

    logic        clk;
    logic        reset;
    logic        start;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic        busy;
    logic        done;
    logic [31:0] result;
    logic        alu_req;
    logic [31:0] alu_srca;
    logic [31:0] alu_srcb;
    logic [3:0]  alu_op;
    logic [31:0] alu_result;

    int checks;
    int errors;

    alu_mul_sequencer #(.DATA_WIDTH(32), .OPCODE_LENGTH(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .op_a       (op_a),
        .op_b       (op_b),
        .busy       (busy),
        .done       (done),
        .result     (result),
        .alu_req    (alu_req),
        .alu_srca   (alu_srca),
        .alu_srcb   (alu_srcb),
        .alu_op     (alu_op),
        .alu_result (alu_result)
    );

    // Shared ALU stand-in: only ADD produces a sum, anything else yields garbage.
    assign alu_result = (alu_op == 4'b0010) ? (alu_srca + alu_srcb) : 32'hDEAD_BEEF;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    function automatic int exp_iters(input logic [31:0] b);
        int n;
`ifdef MUL_EARLY_EXIT_EN
        n = 1;
        for (int i = 0; i < 32; i++) begin
            if (b[i]) n = i + 1;
        end
`else
        n = 32;
`endif
        return n;
    endfunction

    task automatic check_idle_outputs(input string tag);
        check({tag, " busy"},    {31'd0, busy},    32'd0);
        check({tag, " alu_req"}, {31'd0, alu_req}, 32'd0);
        check({tag, " srca"},    alu_srca,         32'd0);
        check({tag, " srcb"},    alu_srcb,         32'd0);
        check({tag, " alu_op"},  {28'd0, alu_op},  32'd0);
    endtask

    // One multiply; inj_iter >= 0 re-asserts start during that ITER sample, inj_done in the DONE cycle.
    task automatic run_mul(input string tag, input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] exp, input int inj_iter, input bit inj_done);
        int n;
        logic [31:0] m_acc, m_mc, m_mp;
        n = exp_iters(b);
        op_a  = a;
        op_b  = b;
        start = 1'b1;
        step();
        start = 1'b0;
        op_a  = 32'h5A5A_5A5A;
        op_b  = 32'hA5A5_A5A5;
        m_acc = 32'd0;
        m_mc  = a;
        m_mp  = b;
        for (int i = 0; i < n; i++) begin
            check($sformatf("%s it%0d busy", tag, i),    {31'd0, busy},    32'd1);
            check($sformatf("%s it%0d alu_req", tag, i), {31'd0, alu_req}, 32'd1);
            check($sformatf("%s it%0d done", tag, i),    {31'd0, done},    32'd0);
            check($sformatf("%s it%0d alu_op", tag, i),  {28'd0, alu_op},  32'd2);
            check($sformatf("%s it%0d srca", tag, i),    alu_srca,         m_acc);
            check($sformatf("%s it%0d srcb", tag, i),    alu_srcb,         m_mp[0] ? m_mc : 32'd0);
            m_acc = m_acc + (m_mp[0] ? m_mc : 32'd0);
            m_mc  = m_mc << 1;
            m_mp  = m_mp >> 1;
            start = (i == inj_iter);
            if (start) begin
                op_a = 32'd9;
                op_b = 32'd9;
            end
            step();
        end
        start = inj_done;
        check({tag, " done"},   {31'd0, done}, 32'd1);
        check({tag, " result"}, result,        exp);
        check_idle_outputs({tag, " DONE"});
        step();
        start = 1'b0;
        check({tag, " done drop"}, {31'd0, done}, 32'd0);
        check_idle_outputs({tag, " after"});
        check({tag, " result hold"}, result, exp);
        step();
        check({tag, " no restart"}, {31'd0, busy}, 32'd0);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        reset  = 1'b1;
        start  = 1'b0;
        op_a   = 32'd0;
        op_b   = 32'd0;
        repeat (2) @(posedge clk);
        #1;
        check("rst done",   {31'd0, done}, 32'd0);
        check("rst result", result,        32'd0);
        check_idle_outputs("rst");
        reset = 1'b0;
        step();

        run_mul("7x6",      32'd7,          32'd6,          32'd42,         -1, 1'b0);
        run_mul("ffxff",    32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'h0000_0001,  -1, 1'b0);
        run_mul("m3x5",     32'hFFFF_FFFD,  32'd5,          32'hFFFF_FFF1,  -1, 1'b0);
        run_mul("ax0",      32'h1234_5678,  32'd0,          32'd0,          -1, 1'b0);
        run_mul("ax1",      32'h1234_5678,  32'd1,          32'h1234_5678,  -1, 1'b0);
        run_mul("0xb",      32'd0,          32'h1234_5678,  32'd0,          -1, 1'b0);
        run_mul("wrap",     32'h0001_0000,  32'h0001_0000,  32'd0,          -1, 1'b0);
        run_mul("x16",      32'hDEAD_BEEF,  32'h0000_0010,  32'hEADB_EEF0,  -1, 1'b0);
        run_mul("ignore",   32'd7,          32'h8000_0003,  32'h8000_0015,  10, 1'b1);

        // Abort mid-operation with an async reset at ITER cycle 15.
        op_a  = 32'h0000_FFFF;
        op_b  = 32'h8000_0001;
        start = 1'b1;
        step();
        start = 1'b0;
        repeat (15) step();
        check("pre-abort busy",   {31'd0, busy}, 32'd1);
        check("pre-abort result", result,        32'h8000_0015);
        reset = 1'b1;
        #1;
        check("abort busy",    {31'd0, busy},    32'd0);
        check("abort alu_req", {31'd0, alu_req}, 32'd0);
        check("abort result",  result,           32'd0);
        check("abort srca",    alu_srca,         32'd0);
        #1;
        reset = 1'b0;
        for (int i = 0; i < 40; i++) begin
            step();
            check($sformatf("abort nodone c%0d", i), {31'd0, done | busy}, 32'd0);
        end

        run_mul("3x4",      32'd3,          32'd4,          32'd12,         -1, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
